// File: rtl/conv_uop_sequencer_if.sv
// conv_uop_sequencer_if: command, RAM-read and PE-array signals of the conv micro-op sequencer.
// Ports (slave = sequencer view):
//   command : cmd_valid/cmd_ready handshake plus ksize, ch, npix, fbase, fstride, cstride, kbase, bias, relu
//   fram    : fram_en/fram_addr request, fram_rdata (PE_NUM packed words, 1-cycle latency)
//   kram    : kram_en/kram_addr request, kram_rdata (one weight, 1-cycle latency)
//   pe array: kernel_data, feature_data, in_valid, out_en, calc_bias, calc_relu, flush; wb_busy back-pressure
//   status  : busy, done
interface conv_uop_sequencer_if #(
    parameter int PE_NUM  = 4,
    parameter int DATA_W  = 8,
    parameter int FRAM_AW = 12,
    parameter int KRAM_AW = 10,
    parameter int KSIZE_W = 3,
    parameter int CH_W    = 6
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [KSIZE_W-1:0]       cmd_ksize;
    logic [CH_W-1:0]          cmd_ch;
    logic [FRAM_AW-1:0]       cmd_npix;
    logic [FRAM_AW-1:0]       cmd_fbase;
    logic [FRAM_AW-1:0]       cmd_fstride;
    logic [FRAM_AW-1:0]       cmd_cstride;
    logic [KRAM_AW-1:0]       cmd_kbase;
    logic                     cmd_bias;
    logic                     cmd_relu;
    logic                     fram_en;
    logic [FRAM_AW-1:0]       fram_addr;
    logic [PE_NUM*DATA_W-1:0] fram_rdata;
    logic                     kram_en;
    logic [KRAM_AW-1:0]       kram_addr;
    logic [DATA_W-1:0]        kram_rdata;
    logic [PE_NUM*DATA_W-1:0] kernel_data;
    logic [PE_NUM*DATA_W-1:0] feature_data;
    logic [PE_NUM-1:0]        in_valid;
    logic [PE_NUM-1:0]        out_en;
    logic [PE_NUM-1:0]        calc_bias;
    logic [PE_NUM-1:0]        calc_relu;
    logic                     flush;
    logic                     wb_busy;
    logic                     busy;
    logic                     done;

    modport master (
        output cmd_valid, cmd_ksize, cmd_ch, cmd_npix, cmd_fbase, cmd_fstride, cmd_cstride,
               cmd_kbase, cmd_bias, cmd_relu, fram_rdata, kram_rdata, wb_busy,
        input  cmd_ready, fram_en, fram_addr, kram_en, kram_addr, kernel_data, feature_data,
               in_valid, out_en, calc_bias, calc_relu, flush, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_ksize, cmd_ch, cmd_npix, cmd_fbase, cmd_fstride, cmd_cstride,
               cmd_kbase, cmd_bias, cmd_relu, fram_rdata, kram_rdata, wb_busy,
        output cmd_ready, fram_en, fram_addr, kram_en, kram_addr, kernel_data, feature_data,
               in_valid, out_en, calc_bias, calc_relu, flush, busy, done
    );
endinterface

// File: rtl/conv_uop_sequencer.sv
// conv_uop_sequencer: sequences one convolution command into per-PE micro-ops.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : conv_uop_sequencer_if.slave -- command handshake, feature/kernel RAM reads,
//              PE-array strobes (in_valid/out_en/calc_bias/calc_relu/flush), wb_busy, busy/done
// Walks pixel groups (outermost), channels, ky, kx (innermost), issuing one tap per cycle.
module conv_uop_sequencer #(
    parameter int PE_NUM  = 4,
    parameter int DATA_W  = 8,
    parameter int FRAM_AW = 12,
    parameter int KRAM_AW = 10,
    parameter int KSIZE_W = 3,
    parameter int CH_W    = 6
) (
    input logic                   clk,
    input logic                   rst,
    conv_uop_sequencer_if.slave   bus
);
    localparam int GW = FRAM_AW + 1;

    typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [KSIZE_W-1:0]  ks_q, ks_d, kx_q, kx_d, ky_q, ky_d;
    logic [CH_W-1:0]     ch_q, ch_d, c_q, c_d;
    logic [FRAM_AW-1:0]  np_q, np_d, fb_q, fb_d, fs_q, fs_d, cs_q, cs_d;
    logic [FRAM_AW-1:0]  roff_q, roff_d, coff_q, coff_d;
    logic [KRAM_AW-1:0]  kb_q, kb_d, tap_q, tap_d;
    logic [GW-1:0]       gpix_q, gpix_d;
    logic                bias_q, bias_d, relu_q, relu_d;
    logic [PE_NUM-1:0]   in_valid_q, in_valid_d, out_en_q, out_en_d, lane_mask;
    logic                issue, last_kx, last_ky, last_c, last_tap, deg_cmd, more_groups;

    always_comb begin
        state_d    = state_q;
        ks_d       = ks_q;
        ch_d       = ch_q;
        np_d       = np_q;
        fb_d       = fb_q;
        fs_d       = fs_q;
        cs_d       = cs_q;
        kb_d       = kb_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        c_d        = c_q;
        tap_d      = tap_q;
        gpix_d     = gpix_q;
        roff_d     = roff_q;
        coff_d     = coff_q;
        issue      = (state_q == RUN) && !bus.wb_busy;
        last_kx    = kx_q == ks_q - KSIZE_W'(1);
        last_ky    = ky_q == ks_q - KSIZE_W'(1);
        last_c     = c_q == ch_q - CH_W'(1);
        last_tap   = last_kx && last_ky && last_c;
        deg_cmd    = (bus.cmd_ksize == '0) || (bus.cmd_ch == '0) || (bus.cmd_npix == '0);
        // gpix is one bit wider than npix so the next-group test cannot wrap
        more_groups = !((ks_q == '0) || (ch_q == '0) || (np_q == '0)) &&
                      ((gpix_q + GW'(PE_NUM)) < {1'b0, np_q});
        for (int i = 0; i < PE_NUM; i++)
            lane_mask[i] = (gpix_q + GW'(i)) < {1'b0, np_q};
        // RAM data returns one cycle after issue, so the strobes are the issue registered once
        in_valid_d = issue ? lane_mask : '0;
        out_en_d   = (issue && last_tap) ? lane_mask : '0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                ks_d    = bus.cmd_ksize;
                ch_d    = bus.cmd_ch;
                np_d    = bus.cmd_npix;
                fb_d    = bus.cmd_fbase;
                fs_d    = bus.cmd_fstride;
                cs_d    = bus.cmd_cstride;
                kb_d    = bus.cmd_kbase;
                bias_d  = bus.cmd_bias;
                relu_d  = bus.cmd_relu;
                kx_d    = '0;
                ky_d    = '0;
                c_d     = '0;
                tap_d   = '0;
                gpix_d  = '0;
                roff_d  = '0;
                coff_d  = '0;
                // an empty command passes through DRAIN, which finds no groups and finishes
                state_d = deg_cmd ? DRAIN : FLUSH;
            end
            FLUSH: state_d = bus.wb_busy ? FLUSH : RUN;
            RUN: if (issue) begin
                kx_d  = last_kx ? '0 : kx_q + KSIZE_W'(1);
                tap_d = last_tap ? '0 : tap_q + KRAM_AW'(1);
                if (last_kx) begin
                    ky_d   = last_ky ? '0 : ky_q + KSIZE_W'(1);
                    roff_d = last_ky ? '0 : roff_q + fs_q;
                end
                if (last_kx && last_ky) begin
                    c_d    = last_c ? '0 : c_q + CH_W'(1);
                    coff_d = last_c ? '0 : coff_q + cs_q;
                end
                if (last_tap) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = more_groups ? FLUSH : DONE;
                gpix_d  = more_groups ? gpix_q + GW'(PE_NUM) : gpix_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ks_q       <= '0;
            ch_q       <= '0;
            np_q       <= '0;
            fb_q       <= '0;
            fs_q       <= '0;
            cs_q       <= '0;
            kb_q       <= '0;
            bias_q     <= 1'b0;
            relu_q     <= 1'b0;
            kx_q       <= '0;
            ky_q       <= '0;
            c_q        <= '0;
            tap_q      <= '0;
            gpix_q     <= '0;
            roff_q     <= '0;
            coff_q     <= '0;
            in_valid_q <= '0;
            out_en_q   <= '0;
        end else begin
            state_q    <= state_d;
            ks_q       <= ks_d;
            ch_q       <= ch_d;
            np_q       <= np_d;
            fb_q       <= fb_d;
            fs_q       <= fs_d;
            cs_q       <= cs_d;
            kb_q       <= kb_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            c_q        <= c_d;
            tap_q      <= tap_d;
            gpix_q     <= gpix_d;
            roff_q     <= roff_d;
            coff_q     <= coff_d;
            in_valid_q <= in_valid_d;
            out_en_q   <= out_en_d;
        end
    end

    assign bus.cmd_ready    = state_q == IDLE;
    assign bus.busy         = state_q != IDLE;
    assign bus.done         = state_q == DONE;
    assign bus.flush        = (state_q == FLUSH) && !bus.wb_busy;
    assign bus.fram_en      = issue;
    assign bus.kram_en      = issue;
    // row and channel offsets are accumulated incrementally, avoiding multipliers
    assign bus.fram_addr    = (state_q == RUN) ?
                              fb_q + gpix_q[FRAM_AW-1:0] + coff_q + roff_q + FRAM_AW'(kx_q) : '0;
    assign bus.kram_addr    = (state_q == RUN) ? kb_q + tap_q : '0;
    assign bus.feature_data = bus.fram_rdata;
    assign bus.in_valid     = in_valid_q;
    assign bus.out_en       = out_en_q;
    assign bus.calc_bias    = out_en_q & {PE_NUM{bias_q}};
    assign bus.calc_relu    = out_en_q & {PE_NUM{relu_q}};

    for (genvar g = 0; g < PE_NUM; g++) begin : g_kbcast
        assign bus.kernel_data[g*DATA_W +: DATA_W] = bus.kram_rdata;
    end
endmodule

// File: doc/conv_uop_sequencer.md
Name: conv_uop_sequencer

Overview:
- Parametrised successor to the conv NPU decoder; sequences one convolution command into per-PE micro-ops.
- Walks output-pixel groups (PE_NUM adjacent pixels per group), input channels and a KxK kernel window.
- Generates feature-RAM and kernel-RAM read addresses, aligns the returned data, and drives in_valid/out_en/calc_bias/calc_relu/flush into the cu PE array.
- Adds what the previous generation lacked: a command handshake, variable kernel size and channel count, partial-group masking, write-back back-pressure and completion status.

Parameters:
- PE_NUM, 4, number of PEs and pixels per group.
- DATA_W, 8, signed operand width.
- FRAM_AW, 12, feature RAM address width.
- KRAM_AW, 10, kernel RAM address width.
- KSIZE_W, 3, kernel dimension width; K up to 7.
- CH_W, 6, channel count width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_ksize  in  KSIZE_W  K; window is KxK.
- cmd_ch  in  CH_W  input channel count.
- cmd_npix  in  FRAM_AW  output pixels to compute.
- cmd_fbase  in  FRAM_AW  feature base address.
- cmd_fstride  in  FRAM_AW  feature row stride.
- cmd_cstride  in  FRAM_AW  feature channel stride.
- cmd_kbase  in  KRAM_AW  kernel base address.
- cmd_bias  in  1  bias enable for the command.
- cmd_relu  in  1  ReLU enable for the command.
- fram_en / fram_addr  out  1 / FRAM_AW  feature read request.
- fram_rdata  in  PE_NUM*DATA_W  PE_NUM packed words; 1-cycle read latency.
- kram_en / kram_addr  out  1 / KRAM_AW  kernel read request.
- kram_rdata  in  DATA_W  weight; 1-cycle read latency.
- kernel_data  out  PE_NUM*DATA_W  kram_rdata broadcast to every PE lane.
- feature_data  out  PE_NUM*DATA_W  fram_rdata passed through unchanged.
- in_valid  out  PE_NUM  per-lane MAC strobe.
- out_en  out  PE_NUM  per-lane result commit.
- calc_bias, calc_relu  out  PE_NUM  per-lane; equal to cmd flag AND out_en.
- flush  out  1  accumulator clear pulse.
- wb_busy  in  1  cu write-back back-pressure.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, all counters 0. All en/valid/flush/done/busy outputs 0 and both addresses 0. cmd_ready is 1 after reset. A reset mid-command aborts it: no done, no further in_valid.
- Command capture: a handshake (cmd_valid & cmd_ready) latches all cmd_* fields.
- Degenerate command: if ksize, ch or npix is 0, go to DONE with no RAM reads.
- Otherwise go to FLUSH. Groups G = ceil(npix/PE_NUM); taps per group T = ch*K*K.
- States:
  - IDLE: wait for a command.
  - FLUSH: flush=1 for one cycle when wb_busy=0. If wb_busy=1, hold in FLUSH with flush=0. Then go to RUN.
  - RUN: one tap per cycle when wb_busy=0, asserting fram_en and kram_en. Loop order, innermost first: kx, ky, ch; group is outermost. wb_busy=1 freezes counters and holds both en low. After the last tap of a group is issued, go to DRAIN.
  - DRAIN: one cycle for the final read to return. Then go to FLUSH if groups remain, else DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Addresses, wrapping modulo 2^AW:
  - fram_addr = fbase + g*PE_NUM + ch*cstride + ky*fstride + kx.
  - kram_addr = kbase + linear tap index (0..T-1); it restarts at kbase each group.
- Data alignment: in_valid is the issue strobe registered by one cycle, so it coincides with valid rdata. Lane i is masked to 0 when g*PE_NUM+i >= npix (partial last group).
- out_en equals in_valid on the last tap of each group and is 0 otherwise.
- Timing, no stall: accept at cycle 0. Group cycles = T+2. done at cycle G*(T+2)+1. Each stall cycle adds one.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- K=3, ch=1, npix=4, kbase=0x10, fbase=0, fstride=8 -> flush @1; kram_addr 0x10..0x18 @2..10; fram_addr 0,1,2,8,9,10,16,17,18; in_valid=1111 @3..11; out_en=1111 @11 only; done @12.
- K=1, ch=2, npix=6, cstride=64, bias=1, relu=1 -> two groups; group 1 fram_addr 4,68; group 1 in_valid=0011; calc_bias=calc_relu=0011 only with group 1 out_en; done @9.
- As scenario 1 with wb_busy=1 for 3 cycles from cycle 5 -> en low and addresses frozen for those cycles; address sequence unchanged; done @15.
- cmd_ksize=0 -> done @2; fram_en, kram_en and in_valid never assert.
- rst=1 at cycle 6 of scenario 1 -> all outputs 0 next cycle, cmd_ready=1, no done; a new command then runs cleanly.
- fbase=0xFFE, K=2, FRAM_AW=12 -> fram_addr wraps to 0xFFE, 0xFFF, 0x006, 0x007 with fstride=8.
